// File: rtl/oven_countdown_timer.sv
// Oven cook-time entry and BCD countdown feeding the magnetron control block.
// Define OVEN_BEEP_EN to add the beep output and its duration counter.
module oven_countdown_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_SECS     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_digit,
    input  logic       key_valid,
    input  logic       clearn,
    input  logic       count_en,
    output logic       timer_done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running
`ifdef OVEN_BEEP_EN
    ,
    output logic       beep
`endif
);

    localparam int            PW     = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [3:0]    mt_nx, mo_nx, st_nx, so_nx;
    logic [3:0]    mt_dec, mo_dec, st_dec, so_dec;
    logic          done_nx;
    logic          tick;
    logic          key_ok;
    logic          key_zero;
    logic          dec_zero;

    assign running  = (state == RUN);
    assign tick     = (state == RUN) && (presc == P_LAST);
    assign key_ok   = key_valid && (key_digit <= 4'd9) && (state != RUN);
    assign key_zero = (min_ones == 4'd0) && (sec_tens == 4'd0) &&
                      (sec_ones == 4'd0) && (key_digit == 4'd0);
    assign dec_zero = (mt_dec == 4'd0) && (mo_dec == 4'd0) &&
                      (st_dec == 4'd0) && (so_dec == 4'd0);

    // Entered values are never normalised, so seconds may borrow from 90.
    always_comb begin
        mt_dec = min_tens;
        mo_dec = min_ones;
        st_dec = sec_tens;
        so_dec = sec_ones;
        if (sec_ones != 4'd0) begin
            so_dec = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
            so_dec = 4'd9;
            st_dec = sec_tens - 4'd1;
        end else if ((min_tens != 4'd0) || (min_ones != 4'd0)) begin
            st_dec = 4'd5;
            so_dec = 4'd9;
            if (min_ones != 4'd0) begin
                mo_dec = min_ones - 4'd1;
            end else begin
                mo_dec = 4'd9;
                mt_dec = min_tens - 4'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        done_nx  = timer_done;
        mt_nx    = min_tens;
        mo_nx    = min_ones;
        st_nx    = sec_tens;
        so_nx    = sec_ones;
        if (!clearn) begin
            state_nx = IDLE;
            presc_nx = '0;
            done_nx  = 1'b0;
            mt_nx    = 4'd0;
            mo_nx    = 4'd0;
            st_nx    = 4'd0;
            so_nx    = 4'd0;
        end else if (state == RUN) begin
            presc_nx = tick ? '0 : presc + PW'(1);
            if (tick) begin
                mt_nx = mt_dec;
                mo_nx = mo_dec;
                st_nx = st_dec;
                so_nx = so_dec;
            end
            // A final tick wins over a simultaneous pause.
            if (tick && dec_zero) begin
                state_nx = DONE;
                done_nx  = 1'b1;
            end else if (!count_en) begin
                state_nx = SET;
            end
        end else if (key_ok) begin
            mt_nx   = min_ones;
            mo_nx   = sec_tens;
            st_nx   = sec_ones;
            so_nx   = key_digit;
            done_nx = 1'b0;
            if (key_zero) begin
                state_nx = IDLE;
                presc_nx = '0;
            end else begin
                state_nx = SET;
            end
        end else if ((state == SET) && count_en) begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            timer_done <= 1'b0;
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
        end else begin
            state      <= state_nx;
            presc      <= presc_nx;
            timer_done <= done_nx;
            min_tens   <= mt_nx;
            min_ones   <= mo_nx;
            sec_tens   <= st_nx;
            sec_ones   <= so_nx;
        end
    end

`ifdef OVEN_BEEP_EN
    localparam int BEEP_LEN = BEEP_SECS * TICKS_PER_SEC;
    localparam int BW       = $clog2(BEEP_LEN + 1);

    logic [BW-1:0] beep_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (!clearn || key_ok) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if ((state != DONE) && (state_nx == DONE)) begin
            beep     <= 1'b1;
            beep_cnt <= '0;
        end else if (beep) begin
            if (beep_cnt == BW'(BEEP_LEN - 1)) begin
                beep <= 1'b0;
            end
            beep_cnt <= beep_cnt + BW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_oven_countdown_timer.sv
// Randomised and directed bench for oven_countdown_timer against a
// seconds/minutes arithmetic model of the countdown.
module tb_oven_countdown_timer;

    localparam int TPS       = 10;
    localparam int BEEP_SECS = 2;
    localparam int BEEP_LEN  = TPS * BEEP_SECS;

    localparam int M_IDLE = 0;
    localparam int M_SET  = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_digit = 4'd0;
    logic       key_valid = 1'b0;
    logic       clearn = 1'b1;
    logic       count_en = 1'b0;
    logic       timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
`ifdef OVEN_BEEP_EN
    logic       beep;
`endif

    oven_countdown_timer #(
        .TICKS_PER_SEC(TPS),
        .BEEP_SECS(BEEP_SECS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_digit(key_digit),
        .key_valid(key_valid),
        .clearn(clearn),
        .count_en(count_en),
        .timer_done(timer_done),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .running(running)
`ifdef OVEN_BEEP_EN
        ,
        .beep(beep)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int mm;
        int ss;
        int mode;
        int presc;
        int done;
        int left;
    } m_t;

    m_t m;
    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;
    logic [15:0] prev_disp = 16'h0;
    bit saw_rollover = 1'b0;

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Time held as minutes and seconds fields; a key appends a decimal digit.
    function automatic m_t step(m_t c, logic kv, logic [3:0] kd,
                                logic ce, logic cl);
        m_t n;
        int v;
        n = c;
        if (n.mode == M_DONE && n.left > 0) n.left = n.left - 1;
        if (!cl) begin
            n = '0;
        end else if (c.mode == M_RUN) begin
            if (c.presc == TPS - 1) begin
                n.presc = 0;
                if (c.ss > 0) begin
                    n.ss = c.ss - 1;
                end else begin
                    n.mm = c.mm - 1;
                    n.ss = 59;
                end
                if (n.mm == 0 && n.ss == 0) begin
                    n.mode = M_DONE;
                    n.done = 1;
                    n.left = BEEP_LEN;
                end else if (!ce) begin
                    n.mode = M_SET;
                end
            end else begin
                n.presc = c.presc + 1;
                if (!ce) n.mode = M_SET;
            end
        end else if (kv && kd <= 4'd9) begin
            v = ((c.mm * 100 + c.ss) * 10 + int'(kd)) % 10000;
            n.mm = v / 100;
            n.ss = v % 100;
            n.done = 0;
            n.left = 0;
            n.mode = (v == 0) ? M_IDLE : M_SET;
            if (v == 0) n.presc = 0;
        end else if (c.mode == M_SET && ce) begin
            n.mode = M_RUN;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else m <= step(m, key_valid, key_digit, count_en, clearn);
    end

    task automatic check(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            check("min_tens", int'(min_tens), m.mm / 10);
            check("min_ones", int'(min_ones), m.mm % 10);
            check("sec_tens", int'(sec_tens), m.ss / 10);
            check("sec_ones", int'(sec_ones), m.ss % 10);
            check("timer_done", int'(timer_done), m.done);
            check("running", int'(running), int'(m.mode == M_RUN));
`ifdef OVEN_BEEP_EN
            check("beep", int'(beep), int'(m.left > 0));
`endif
            if (prev_disp == 16'h0100 && disp() == 16'h0059)
                saw_rollover <= 1'b1;
            prev_disp <= disp();
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic clr();
        clearn = 1'b0;
        @(negedge clk);
        clearn = 1'b1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!timer_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        cyc(2);
        rst = 1'b0;
        started = 1'b1;
        check("reset_disp", int'(disp()), 0);
        check("reset_done", int'(timer_done), 0);
        check("reset_running", int'(running), 0);

        press(4'd0); press(4'd1); press(4'd0); press(4'd5);
        check("entry_0105", int'(disp()), 'h0105);
        check("entry_not_running", int'(running), 0);
        count_en = 1'b1;
        cyc(1);
        check("run_start", int'(running), 1);
        wait_done(n);
        check("cycles_0105", n, 650);
        check("done_disp", int'(disp()), 0);
        check("rollover_0100_0059", int'(saw_rollover), 1);

        count_en = 1'b0;
        press(4'd4);
        check("done_key_disp", int'(disp()), 'h0004);
        check("done_key_clears_done", int'(timer_done), 0);
        check("done_key_not_running", int'(running), 0);
        count_en = 1'b1;
        cyc(1);
        wait_done(n);
        check("cycles_0004", n, 40);
`ifdef OVEN_BEEP_EN
        n = 0;
        while (beep && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("beep_len", n, BEEP_LEN);
`endif
        count_en = 1'b0;
        clr();
        check("done_clear_disp", int'(disp()), 0);
        check("done_clear_done", int'(timer_done), 0);

        press(4'd9); press(4'd0);
        check("entry_0090", int'(disp()), 'h0090);
        count_en = 1'b1;
        cyc(1);
        cyc(10);
        check("first_dec_0089", int'(disp()), 'h0089);
        wait_done(n);
        check("cycles_0090", n + 10, 900);
        count_en = 1'b0;
        clr();

        press(4'd0); press(4'd3);
        count_en = 1'b1;
        cyc(15);
        count_en = 1'b0;
        cyc(50);
        check("pause_disp", int'(disp()), 'h0002);
        check("pause_running", int'(running), 0);
        count_en = 1'b1;
        n = 0;
        while (disp() != 16'h0001 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("resume_latency", n, 6);
        press(4'hB); press(4'd7);
        check("run_keys_ignored", int'(disp()), 'h0001);
        count_en = 1'b0;
        cyc(1);
        press(4'hC);
        check("set_bad_key", int'(disp()), 'h0001);
        check("set_not_running", int'(running), 0);

        clr();
        press(4'd4); press(4'd0);
        count_en = 1'b1;
        cyc(3);
        check("run_0040", int'(disp()), 'h0040);
        clearn = 1'b0;
        count_en = 1'b0;
        cyc(1);
        clearn = 1'b1;
        check("run_clear_disp", int'(disp()), 0);
        check("run_clear_running", int'(running), 0);

        press(4'd1); press(4'd2);
        count_en = 1'b1;
        cyc(25);
        #2 rst = 1'b1;
        #1;
        check("async_rst_disp", int'(disp()), 0);
        check("async_rst_running", int'(running), 0);
        check("async_rst_done", int'(timer_done), 0);
        @(negedge clk);
        rst = 1'b0;
        count_en = 1'b0;

        repeat (4000) begin
            key_valid = ($urandom % 4 == 0);
            key_digit = 4'($urandom % 16);
            if ($urandom % 40 == 0) count_en = ~count_en;
            clearn = ($urandom % 300 != 0);
            @(negedge clk);
        end
        key_valid = 1'b0;
        clearn = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
